serial_alu_seq: RTL and testbench

- Bit-serial arithmetic sequencer for the COMET2 ALU.
- Time-shares a single 1-bit full adder (existing `fa` cell) across WIDTH cycles to execute ADDA/SUBA/ADDL/SUBL.
- Produces the 16-bit result plus OF/SF/ZF flags.
- Sits between the instruction decoder (start/op) and the flag register.
- Gives a minimum-area ALU option alongside the ripple adder.

---
 rtl/serial_alu_seq_pkg.sv | 19 +
 rtl/serial_alu_seq_fa.sv | 13 +
 rtl/serial_alu_seq.sv | 144 ++++++++++++++
 tb/tb_serial_alu_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_seq_pkg.sv
// rtl/serial_alu_seq_pkg.sv - shared op/state encodings and default width for the bit-serial ALU
package serial_alu_seq_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        OP_ADDA = 2'b00,
        OP_SUBA = 2'b01,
        OP_ADDL = 2'b10,
        OP_SUBL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/serial_alu_seq_fa.sv
// rtl/serial_alu_seq_fa.sv - 1-bit full adder cell shared across all bit positions
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_alu_seq.sv
// rtl/serial_alu_seq.sv - bit-serial add/subtract sequencer producing result and OF/SF/ZF
module serial_alu_seq
    import serial_alu_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             of,
    output logic             sf,
    output logic             zf
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   sreg_a_q, sreg_a_d;
    logic [WIDTH-1:0]   sreg_b_q, sreg_b_d;
    logic [WIDTH-1:0]   sreg_r_q, sreg_r_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               of_q, of_d;
    logic               sf_q, sf_d;
    logic               zf_q, zf_d;

    logic               fa_s;
    logic               fa_cout;
    logic [WIDTH-1:0]   sum_shifted;

    // The single adder sees the current LSBs of both operand shift registers.
    fa fa0 (
        .a    (sreg_a_q[0]),
        .b    (sreg_b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Sum bit enters at the MSB; after WIDTH shifts the LSB of the result sits at bit 0.
    assign sum_shifted = {fa_s, sreg_r_q[WIDTH-1:1]};

    // Next-state, datapath update and flag computation.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sreg_a_d = sreg_a_q;
        sreg_b_d = sreg_b_q;
        sreg_r_d = sreg_r_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        of_d     = of_q;
        sf_d     = sf_q;
        zf_d     = zf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d     = op_e'(op);
                    sreg_a_d = a;
                    // Subtraction is A + ~B + 1: invert B and preload the carry.
                    sreg_b_d = op[0] ? ~b : b;
                    carry_d  = op[0];
                    sreg_r_d = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                sreg_r_d = sum_shifted;
                sreg_a_d = sreg_a_q >> 1;
                sreg_b_d = sreg_b_q >> 1;
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    result_d = sum_shifted;
                    sf_d     = fa_s;
                    zf_d     = (sum_shifted == '0);
                    // carry_q here is the carry into the MSB, fa_cout the carry out.
                    case (op_q)
                        OP_ADDA, OP_SUBA: of_d = carry_q ^ fa_cout;
                        OP_ADDL:          of_d = fa_cout;
                        OP_SUBL:          of_d = ~fa_cout;
                        default:          of_d = 1'b0;
                    endcase
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADDA;
            sreg_a_q <= '0;
            sreg_b_q <= '0;
            sreg_r_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            of_q     <= 1'b0;
            sf_q     <= 1'b0;
            zf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sreg_a_q <= sreg_a_d;
            sreg_b_q <= sreg_b_d;
            sreg_r_q <= sreg_r_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            of_q     <= of_d;
            sf_q     <= sf_d;
            zf_q     <= zf_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign of     = of_q;
    assign sf     = sf_q;
    assign zf     = zf_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// tb/tb_serial_alu_seq.sv - scoreboard bench for serial_alu_seq with an integer-arithmetic reference
module tb_serial_alu_seq;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] res;
        logic         of;
        logic         sf;
        logic         zf;
        int           start_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         of;
    logic         sf;
    logic         zf;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cycle_cnt = 0;
    int   busy_len = 0;
    logic rst_at_edge = 1'b1;

    serial_alu_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .of     (of),
        .sf     (sf),
        .zf     (zf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle_cnt   <= cycle_cnt + 1;
        rst_at_edge <= rst;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic, overflow judged by range of the exact result.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t m;
        int   sx;
        int   sy;
        int   ux;
        int   uy;
        int   full;
        sx = int'($signed(x));
        sy = int'($signed(y));
        ux = int'({16'h0000, x});
        uy = int'({16'h0000, y});
        case (o)
            2'b00: begin full = sx + sy; m.of = (full > 32767) || (full < -32768); end
            2'b01: begin full = sx - sy; m.of = (full > 32767) || (full < -32768); end
            2'b10: begin full = ux + uy; m.of = (full > 65535); end
            default: begin full = ux - uy; m.of = (full < 0); end
        endcase
        m.res = full[W-1:0];
        m.sf = m.res[W-1];
        m.zf = (m.res == 0);
        m.start_cyc = 0;
        return m;
    endfunction

    // Monitor: pops an expectation whenever done is presented, and checks busy length.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("of", of, e.of);
                check("sf", sf, e.sf);
                check("zf", zf, e.zf);
                check("latency", cycle_cnt - e.start_cyc, W);
            end
        end
        if (rst_at_edge) begin
            busy_len = 0;
        end else if (busy) begin
            busy_len++;
        end else if (busy_len != 0) begin
            check("busy_len", busy_len, W + 1);
            busy_len = 0;
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
        exp_t e;
        int   t;
        bit   got;
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        e = model(o, x, y);
        e.start_cyc = cycle_cnt;
        sb.push_back(e);
        if (!hold) start = 1'b0;
        got = 0;
        t = 0;
        while (!got && t < 40) begin
            @(negedge clk);
            t++;
            if (hold && t == 5) begin
                a = W'($urandom);
                b = W'($urandom);
                op = 2'($urandom);
            end
            if (done) got = 1;
        end
        if (!got) check("done_timeout", 0, 1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'hFFFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_of", of, 0);
        check("rst_sf", sf, 0);
        check("rst_zf", zf, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(2'b00, 16'h7FFF, 16'h0001, 0);
        run_op(2'b01, 16'h0005, 16'h0005, 0);
        run_op(2'b01, 16'h8000, 16'h0001, 0);
        run_op(2'b10, 16'hFFFF, 16'h0001, 0);
        run_op(2'b10, 16'h1234, 16'h4321, 0);
        run_op(2'b11, 16'h0001, 16'h0002, 0);
        run_op(2'b11, 16'h0002, 16'h0001, 0);

        run_op(2'b00, 16'h1111, 16'h2222, 1);
        run_op(2'b11, 16'h0100, 16'h0200, 0);

        run_op(2'b10, 16'h1234, 16'h4321, 0);
        @(negedge clk);
        start = 1'b1;
        op = 2'b00;
        a = 16'h7FFF;
        b = 16'h0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        check("abort_of", of, 0);
        check("abort_sf", sf, 0);
        check("abort_zf", zf, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (24) @(negedge clk);
        run_op(2'b00, 16'h7FFF, 16'h0001, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom), pick(), pick(), ($urandom_range(0, 4) == 0));
        end
        @(negedge clk);
        start = 1'b0;

        t = 0;
        while (sb.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
